// File: rtl/lsu_pkg.sv
// Shared codes for the load/store unit: access sizes, load types, FSM states.
// Also holds the alignment rule and the load-type encoder.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] LT_LB  = 2'b00;
  localparam logic [1:0] LT_LH  = 2'b01;
  localparam logic [1:0] LT_LBU = 2'b10;
  localparam logic [1:0] LT_LHU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Reserved size behaves like a word access.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: m = 1'b0;
      size == SZ_HALF: m = off[0];
      default:         m = (off != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [1:0] load_type(
    input logic [1:0] size,
    input logic       uns
  );
    logic [1:0] lt;
    lt = LT_LB;
    unique case (1'b1)
      size == SZ_HALF && uns:  lt = LT_LHU;
      size == SZ_HALF && !uns: lt = LT_LH;
      size == SZ_BYTE && uns:  lt = LT_LBU;
      default:                 lt = LT_LB;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/load_store_unit_store_aligner.sv
// Store lane mapper: replicates store data across lanes and builds
// byte enables from access size and byte offset.
module store_aligner
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be
);

  always_comb begin
    bus_wdata = wdata;
    bus_be    = 4'b1111;
    unique case (1'b1)
      size == SZ_BYTE: begin
        bus_wdata = {4{wdata[7:0]}};
        bus_be    = 4'b0001 << offset;
      end
      size == SZ_HALF: begin
        bus_wdata = {2{wdata[15:0]}};
        bus_be    = 4'b0011 << offset;
      end
      default: begin
        bus_wdata = wdata;
        bus_be    = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store, runs a req/ack bus
// access with timeout, and hands the raw word to the load extender.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_mem_data,
  output logic [1:0]  rsp_byte_offset,
  output logic [1:0]  rsp_load_type,
  output logic        rsp_word,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_size;
  logic [1:0]       lat_off;
  logic             lat_uns;

  logic             mis;
  logic             to_hit;
  logic [31:0]      al_wdata;
  logic [3:0]       al_be;

  store_aligner u_align (
    .size      (req_size),
    .offset    (req_addr[1:0]),
    .wdata     (req_wdata),
    .bus_wdata (al_wdata),
    .bus_be    (al_be)
  );

  assign mis    = misaligned(req_size, req_addr[1:0]);
  assign to_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Low in RESP so the core can retire on rsp_* that cycle.
  assign stall = ((state == ST_IDLE) && req_valid && !mis)
               || (state == ST_BUS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      lat_size        <= 2'b00;
      lat_off         <= 2'b00;
      lat_uns         <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_mem_data    <= 32'h0;
      rsp_byte_offset <= 2'b00;
      rsp_load_type   <= 2'b00;
      rsp_word        <= 1'b0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= 32'h0;
      bus_wdata       <= 32'h0;
      bus_be          <= 4'h0;
    end else begin
      rsp_valid <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid && mis) begin
            misalign <= 1'b1;
          end else if (req_valid) begin
            lat_size  <= req_size;
            lat_off   <= req_addr[1:0];
            lat_uns   <= req_unsigned;
            bus_req   <= 1'b1;
            bus_we    <= req_write;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_wdata <= al_wdata;
            bus_be    <= req_write ? al_be : 4'b1111;
            cnt       <= '0;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ack in the timeout cycle still completes the access.
          if (bus_ack) begin
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
            if (!bus_we) begin
              rsp_mem_data    <= bus_rdata;
              rsp_byte_offset <= lat_off;
              rsp_load_type   <= load_type(lat_size, lat_uns);
              rsp_word        <= lat_size[1];
            end
          end else if (to_hit) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential data-memory access stage that sits directly upstream of the load extender.
- Accepts one load/store request from the core and aligns store data and byte enables.
- Runs a variable-latency req/ack handshake to data memory and stalls the core while the access is outstanding.
- Presents the raw memory word, byte offset and load type to the load extender, and flags misalignment and bus timeout.

Parameters:
- TIMEOUT, 255: maximum cycles in BUS waiting for bus_ack before aborting with bus_err (1..1023).
- CNT_W, 10: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core requests a memory access.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  selects lbu/lhu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  core must hold the current instruction.
- rsp_valid  out  1  one-cycle pulse: access completed.
- rsp_mem_data  out  32  captured bus_rdata (loads).
- rsp_byte_offset  out  2  addr[1:0] of the completed load.
- rsp_load_type  out  2  00 lb, 01 lh, 10 lbu, 11 lhu.
- rsp_word  out  1  completed load is lw; downstream muxes rsp_mem_data past the extender.
- misalign  out  1  one-cycle pulse: misaligned request rejected.
- bus_err  out  1  one-cycle pulse: timeout abort.
- bus_req  out  1  memory request, held until ack.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  memory completes the access this cycle.
- bus_rdata  in  32  read data, valid when bus_ack=1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; every registered output 0, including bus_req, rsp_*, misalign, bus_err and the counter. This applies mid-access; a late bus_ack arriving in IDLE is ignored.
- States: IDLE, BUS, RESP.
- IDLE:
  - A request is misaligned for half with addr[0]=1, or word/reserved with addr[1:0]!=0.
  - On req_valid and misaligned: misalign=1 next cycle, no bus activity, stay IDLE.
  - On req_valid and aligned: latch the request, drive the bus registers, clear the counter, go to BUS. bus_req rises the cycle after acceptance.
- Store lane mapping:
  - byte: wdata={4{d[7:0]}}, be=0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be=0011<<addr[1:0].
  - word: be=1111.
  - Loads: be=1111, bus_we=0.
- BUS:
  - bus_req/bus_we/bus_addr/bus_wdata/bus_be are held stable until ack.
  - On bus_ack: capture bus_rdata into rsp_mem_data (loads only; stores leave it unchanged), drop bus_req next cycle, go to RESP. Minimum latency is acceptance→rsp_valid in 2 cycles when ack comes on the first BUS cycle.
  - No ack and counter==TIMEOUT-1: drop bus_req, pulse bus_err, go to IDLE. If ack arrives in that same cycle, ack wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_load_type, rsp_byte_offset and rsp_word hold until the next completion.
- stall (combinational) = (IDLE & req_valid & aligned) | BUS. It is low in RESP, so the core retires using rsp_* that cycle, and low on a misaligned request.
- A back-to-back req_valid during RESP is ignored; it is accepted on the following IDLE cycle.

Decomposition:
- Package lsu_pkg: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), load-type codes (LT_LB/LT_LH/LT_LBU/LT_LHU), state encoding.
- One combinational sub-module, store_aligner: maps (size, addr[1:0], wdata) to (bus_wdata, bus_be).

Test Plan:
- Reset mid-access: rst_n=0 for one cycle while in BUS → bus_req=0 next cycle; an ack two cycles later produces no rsp_valid.
- sb addr=0x1003 data=0x000000AB, ack after 3 cycles → bus_addr=0x1000, be=1000, wdata=0xABABABAB, rsp_valid 1 cycle after ack, stall high 4 cycles.
- lh addr=0x2002, rdata=0x8001_1234, ack first BUS cycle → rsp_mem_data=0x80011234, rsp_byte_offset=10, rsp_load_type=01, rsp_word=0.
- lw addr=0x3001 → misalign pulse, bus_req never rises, stall=0.
- lbu addr=0x4000, no ack, TIMEOUT=4 → bus_err pulse after 4 BUS cycles, IDLE; ack exactly at cycle 4 instead yields rsp_valid and no bus_err.
- lw addr=0x5000, rdata=0xDEADBEEF → rsp_word=1, rsp_mem_data=0xDEADBEEF, be=1111.
